// File: rtl/fcc_way_arbiter_pkg.sv
// Shared types and constants for the fcc_core way arbiter: per-way dispatch
// states, default lock timeout and index-width helper.
package fcc_way_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_LOCK = 2'd2,
        ST_FIN  = 2'd3
    } way_state_e;

    localparam int TIMEOUT_DEFAULT = 4095;
    localparam int WAY_MAX         = 8;
    localparam int SEL_W           = 3;

    // A single way still needs a 1-bit index so ports never collapse to zero width.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/fcc_rr_picker.sv
// Combinational round-robin picker: scans req starting at 'start' (inclusive,
// wrapping) and returns the first hit as one-hot grant plus binary index.
module fcc_rr_picker
    import fcc_way_arbiter_pkg::*;
#(
    parameter int N  = 1,
    parameter int IW = idx_width(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] start,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] index,
    output logic          any
);

    localparam int PW = IW + 1;

    logic [PW-1:0] pos;
    logic [IW-1:0] cand;

    always_comb begin
        grant = '0;
        index = '0;
        any   = 1'b0;
        pos   = '0;
        cand  = '0;
        for (int i = 0; i < N; i++) begin
            pos = {1'b0, start} + PW'(i);
            if (pos >= PW'(N))
                pos = pos - PW'(N);
            cand = pos[IW-1:0];
            if (!any && req[cand]) begin
                any         = 1'b1;
                grant[cand] = 1'b1;
                index       = cand;
            end
        end
    end

endmodule

// File: rtl/fcc_way_arbiter.sv
// Shares one NAND channel between WAY_NUM scheduler/executer pairs: per-way
// dispatch FSMs feed executers one at a time, and a round-robin bus arbiter owns DQ/DQS.
module fcc_way_arbiter
    import fcc_way_arbiter_pkg::*;
#(
    parameter int WAY_NUM = 1,
    parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic               usr_clk,
    input  logic               usr_rst_n,
    input  logic [WAY_NUM-1:0] i_sched_valid,
    output logic [WAY_NUM-1:0] o_sched_ready,
    output logic [WAY_NUM-1:0] o_exec_valid,
    input  logic [WAY_NUM-1:0] i_exec_ready,
    input  logic [WAY_NUM-1:0] i_bus_req,
    output logic [WAY_NUM-1:0] o_keep_wait,
    output logic [WAY_NUM-1:0] o_bus_grant,
    output logic [2:0]         o_bus_sel,
    output logic [WAY_NUM-1:0] o_timeout
);

    localparam int IW = idx_width(WAY_NUM);
    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);
    localparam logic [CW-1:0] CNT_MAX  = CW'(TIMEOUT);

    function automatic logic [IW-1:0] wrap_inc(input logic [IW-1:0] p);
        if (p == IW'(WAY_NUM - 1))
            return '0;
        return p + 1'b1;
    endfunction

    // ---------------- dispatch picker ----------------
    logic [WAY_NUM-1:0] wait_vec;
    logic [WAY_NUM-1:0] disp_grant;
    logic [IW-1:0]      disp_idx;
    logic [IW-1:0]      disp_ptr;
    logic [IW-1:0]      disp_start;
    logic               disp_any;
    logic               disp_primed;

    // Until the first pick there is no "last winner", so the scan begins at way 0 itself.
    assign disp_start = disp_primed ? wrap_inc(disp_ptr) : disp_ptr;

    fcc_rr_picker #(.N(WAY_NUM), .IW(IW)) u_disp_pick (
        .req   (wait_vec),
        .start (disp_start),
        .grant (disp_grant),
        .index (disp_idx),
        .any   (disp_any)
    );

    always_ff @(posedge usr_clk) begin
        if (!usr_rst_n) begin
            disp_ptr    <= '0;
            disp_primed <= 1'b0;
        end else if (disp_any) begin
            disp_ptr    <= disp_idx;
            disp_primed <= 1'b1;
        end
    end

    // ---------------- per-way dispatch FSMs ----------------
    logic [WAY_NUM-1:0] sched_ready_d;
    logic [WAY_NUM-1:0] exec_valid_d;
    logic [WAY_NUM-1:0] timeout_d;

    for (genvar w = 0; w < WAY_NUM; w++) begin : g_way
        way_state_e    state;
        way_state_e    state_nx;
        logic [CW-1:0] cnt;
        logic          to_hit;

        always_comb begin
            state_nx = state;
            to_hit   = 1'b0;
            case (state)
                ST_IDLE: if (i_sched_valid[w]) state_nx = ST_WAIT;
                ST_WAIT: if (disp_grant[w])    state_nx = ST_LOCK;
                ST_LOCK: begin
                    // A ready drop on the last allowed cycle still counts as accepted.
                    if (!i_exec_ready[w]) begin
                        state_nx = ST_FIN;
                    end else if (cnt == CNT_LAST) begin
                        state_nx = ST_IDLE;
                        to_hit   = 1'b1;
                    end
                end
                ST_FIN:  if (i_exec_ready[w])  state_nx = ST_IDLE;
                default: state_nx = ST_IDLE;
            endcase
        end

        always_ff @(posedge usr_clk) begin
            if (!usr_rst_n) begin
                state <= ST_IDLE;
                cnt   <= '0;
            end else begin
                state <= state_nx;
                if (state != ST_LOCK)
                    cnt <= '0;
                else if (cnt != CNT_MAX)
                    cnt <= cnt + 1'b1;
            end
        end

        assign wait_vec[w]      = (state == ST_WAIT);
        assign sched_ready_d[w] = (state == ST_IDLE) && !i_sched_valid[w];
        assign exec_valid_d[w]  = (state_nx == ST_LOCK);
        assign timeout_d[w]     = to_hit;
    end

    always_ff @(posedge usr_clk) begin
        if (!usr_rst_n) begin
            o_sched_ready <= '0;
            o_exec_valid  <= '0;
            o_timeout     <= '0;
        end else begin
            o_sched_ready <= sched_ready_d;
            o_exec_valid  <= exec_valid_d;
            o_timeout     <= timeout_d;
        end
    end

    // ---------------- bus arbiter ----------------
    logic [WAY_NUM-1:0] bus_pick;
    logic [IW-1:0]      bus_idx;
    logic [IW-1:0]      bus_ptr;
    logic [IW-1:0]      bus_start;
    logic               bus_any;
    logic               bus_primed;
    logic               owned;

    assign bus_start = bus_primed ? wrap_inc(bus_ptr) : bus_ptr;

    fcc_rr_picker #(.N(WAY_NUM), .IW(IW)) u_bus_pick (
        .req   (i_bus_req),
        .start (bus_start),
        .grant (bus_pick),
        .index (bus_idx),
        .any   (bus_any)
    );

    // bus_ptr doubles as the owner index; arbitration only runs with no owner,
    // which forces one grant-free cycle between release and the next grant.
    always_ff @(posedge usr_clk) begin
        if (!usr_rst_n) begin
            owned       <= 1'b0;
            bus_ptr     <= '0;
            bus_primed  <= 1'b0;
            o_bus_grant <= '0;
            o_keep_wait <= '1;
            o_bus_sel   <= '0;
        end else if (owned) begin
            if (!i_bus_req[bus_ptr]) begin
                owned       <= 1'b0;
                o_bus_grant <= '0;
                o_keep_wait <= '1;
                o_bus_sel   <= '0;
            end
        end else if (bus_any) begin
            owned       <= 1'b1;
            bus_ptr     <= bus_idx;
            bus_primed  <= 1'b1;
            o_bus_grant <= bus_pick;
            o_keep_wait <= ~bus_pick;
            o_bus_sel   <= SEL_W'(bus_idx);
        end
    end

endmodule

// File: tb/tb_fcc_way_arbiter.sv
// Directed bench: a 4-way (TIMEOUT=8) instance driven from a vector table plus
// a 1-way instance and a mid-run reset covered by short hand-written sequences.
module tb_fcc_way_arbiter;

    logic clk;
    logic rst_n;

    logic [3:0] sv4, sr4, ev4, er4, br4, kw4, gr4, to4;
    logic [2:0] sel4;
    logic [0:0] sv1, sr1, ev1, er1, br1, kw1, gr1, to1;
    logic [2:0] sel1;

    int n_run  = 0;
    int n_fail = 0;

    fcc_way_arbiter #(.WAY_NUM(4), .TIMEOUT(8)) u_dut4 (
        .usr_clk       (clk),
        .usr_rst_n     (rst_n),
        .i_sched_valid (sv4),
        .o_sched_ready (sr4),
        .o_exec_valid  (ev4),
        .i_exec_ready  (er4),
        .i_bus_req     (br4),
        .o_keep_wait   (kw4),
        .o_bus_grant   (gr4),
        .o_bus_sel     (sel4),
        .o_timeout     (to4)
    );

    fcc_way_arbiter #(.WAY_NUM(1)) u_dut1 (
        .usr_clk       (clk),
        .usr_rst_n     (rst_n),
        .i_sched_valid (sv1),
        .o_sched_ready (sr1),
        .o_exec_valid  (ev1),
        .i_exec_ready  (er1),
        .i_bus_req     (br1),
        .o_keep_wait   (kw1),
        .o_bus_grant   (gr1),
        .o_bus_sel     (sel1),
        .o_timeout     (to1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] sv, er, br;
        logic [3:0] sr, ev, gr, kw, to;
        logic [2:0] sel;
    } vec_t;

    vec_t tbl[$];

    task automatic add_vec(input logic [3:0] sv, er, br, sr, ev, gr, kw,
                           input logic [2:0] sel, input logic [3:0] to);
        vec_t v;
        v.sv = sv; v.er = er; v.br = br;
        v.sr = sr; v.ev = ev; v.gr = gr; v.kw = kw; v.sel = sel; v.to = to;
        tbl.push_back(v);
    endtask

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_run++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset4(input string tag);
        check({tag, ".sr"},  8'(sr4),  8'h0);
        check({tag, ".ev"},  8'(ev4),  8'h0);
        check({tag, ".gr"},  8'(gr4),  8'h0);
        check({tag, ".kw"},  8'(kw4),  8'hf);
        check({tag, ".sel"}, 8'(sel4), 8'h0);
        check({tag, ".to"},  8'(to4),  8'h0);
    endtask

    initial begin
        // Table: dispatch order, bus handoff, timeout, and dispatch/grant overlap.
        //       sv       er       br       sr       ev       gr       kw       sel   to
        add_vec(4'b0000, 4'b1111, 4'b0101, 4'b1111, 4'b0000, 4'b0001, 4'b1110, 3'd0, 4'b0000);
        add_vec(4'b1111, 4'b1111, 4'b0101, 4'b0000, 4'b0000, 4'b0001, 4'b1110, 3'd0, 4'b0000);
        add_vec(4'b1111, 4'b1111, 4'b0101, 4'b0000, 4'b0001, 4'b0001, 4'b1110, 3'd0, 4'b0000);
        add_vec(4'b1111, 4'b1111, 4'b0100, 4'b0000, 4'b0011, 4'b0000, 4'b1111, 3'd0, 4'b0000);
        add_vec(4'b1111, 4'b1111, 4'b0100, 4'b0000, 4'b0111, 4'b0100, 4'b1011, 3'd2, 4'b0000);
        add_vec(4'b1111, 4'b1111, 4'b0100, 4'b0000, 4'b1111, 4'b0100, 4'b1011, 3'd2, 4'b0000);
        add_vec(4'b1111, 4'b0000, 4'b0100, 4'b0000, 4'b0000, 4'b0100, 4'b1011, 3'd2, 4'b0000);
        add_vec(4'b1111, 4'b1111, 4'b0100, 4'b0000, 4'b0000, 4'b0100, 4'b1011, 3'd2, 4'b0000);
        add_vec(4'b1111, 4'b1111, 4'b0100, 4'b0000, 4'b0000, 4'b0100, 4'b1011, 3'd2, 4'b0000);
        add_vec(4'b1111, 4'b1111, 4'b0100, 4'b0000, 4'b0001, 4'b0100, 4'b1011, 3'd2, 4'b0000);
        add_vec(4'b1111, 4'b1111, 4'b0100, 4'b0000, 4'b0011, 4'b0100, 4'b1011, 3'd2, 4'b0000);
        add_vec(4'b0000, 4'b1111, 4'b0100, 4'b0000, 4'b0111, 4'b0100, 4'b1011, 3'd2, 4'b0000);
        add_vec(4'b0000, 4'b1111, 4'b0100, 4'b0000, 4'b1111, 4'b0100, 4'b1011, 3'd2, 4'b0000);
        for (int k = 0; k < 4; k++)
            add_vec(4'b0000, 4'b1111, 4'b0100, 4'b0000, 4'b1111, 4'b0100, 4'b1011, 3'd2, 4'b0000);
        add_vec(4'b0000, 4'b1111, 4'b0100, 4'b0000, 4'b1110, 4'b0100, 4'b1011, 3'd2, 4'b0001);
        add_vec(4'b0000, 4'b1111, 4'b0100, 4'b0001, 4'b1100, 4'b0100, 4'b1011, 3'd2, 4'b0010);
        add_vec(4'b0000, 4'b1111, 4'b0100, 4'b0011, 4'b1000, 4'b0100, 4'b1011, 3'd2, 4'b0100);
        add_vec(4'b0000, 4'b1111, 4'b0100, 4'b0111, 4'b0000, 4'b0100, 4'b1011, 3'd2, 4'b1000);
        add_vec(4'b0000, 4'b1111, 4'b0100, 4'b1111, 4'b0000, 4'b0100, 4'b1011, 3'd2, 4'b0000);
        add_vec(4'b0010, 4'b1111, 4'b0001, 4'b1101, 4'b0000, 4'b0000, 4'b1111, 3'd0, 4'b0000);
        add_vec(4'b0010, 4'b1111, 4'b0001, 4'b1101, 4'b0010, 4'b0001, 4'b1110, 3'd0, 4'b0000);
        add_vec(4'b0000, 4'b1111, 4'b0001, 4'b1101, 4'b0010, 4'b0001, 4'b1110, 3'd0, 4'b0000);
        add_vec(4'b0000, 4'b1111, 4'b0010, 4'b1101, 4'b0010, 4'b0000, 4'b1111, 3'd0, 4'b0000);
        add_vec(4'b0000, 4'b1111, 4'b0010, 4'b1101, 4'b0010, 4'b0010, 4'b1101, 3'd1, 4'b0000);

        // ---- reset state ----
        rst_n = 1'b0;
        sv4 = '0; er4 = '1; br4 = '0;
        sv1 = '0; er1 = '1; br1 = '0;
        step();
        step();
        check_reset4("rst");
        check("rst.sr1", 8'(sr1), 8'h0);
        check("rst.kw1", 8'(kw1), 8'h1);
        check("rst.gr1", 8'(gr1), 8'h0);
        rst_n = 1'b1;

        // ---- single way: IDLE, WAIT, LOCK, FIN, IDLE seen through exec_valid ----
        sv1 = 1'b1; er1 = 1'b1; br1 = 1'b1;
        step();
        check("w1.wait.ev", 8'(ev1), 8'h0);
        check("w1.gr",      8'(gr1), 8'h1);
        check("w1.kw",      8'(kw1), 8'h0);
        check("w1.sel",     8'(sel1), 8'h0);
        for (int k = 0; k < 3; k++) begin
            step();
            check($sformatf("w1.lock%0d.ev", k), 8'(ev1), 8'h1);
        end
        er1 = 1'b0;
        for (int k = 0; k < 20; k++) begin
            step();
            check($sformatf("w1.fin%0d.ev", k), 8'(ev1), 8'h0);
        end
        check("w1.fin.sr", 8'(sr1), 8'h0);
        er1 = 1'b1;
        step();
        check("w1.idle.ev", 8'(ev1), 8'h0);
        step();
        check("w1.rewait.ev", 8'(ev1), 8'h0);
        step();
        check("w1.relock.ev", 8'(ev1), 8'h1);
        check("w1.relock.to", 8'(to1), 8'h0);
        br1 = 1'b0;
        step();
        check("w1.rel.gr", 8'(gr1), 8'h0);
        check("w1.rel.kw", 8'(kw1), 8'h1);
        sv1 = 1'b0; er1 = 1'b0;

        // ---- 4-way table ----
        for (int i = 0; i < tbl.size(); i++) begin
            sv4 = tbl[i].sv; er4 = tbl[i].er; br4 = tbl[i].br;
            step();
            check($sformatf("row%0d.sr", i),  8'(sr4),  8'(tbl[i].sr));
            check($sformatf("row%0d.ev", i),  8'(ev4),  8'(tbl[i].ev));
            check($sformatf("row%0d.gr", i),  8'(gr4),  8'(tbl[i].gr));
            check($sformatf("row%0d.kw", i),  8'(kw4),  8'(tbl[i].kw));
            check($sformatf("row%0d.sel", i), 8'(sel4), 8'(tbl[i].sel));
            check($sformatf("row%0d.to", i),  8'(to4),  8'(tbl[i].to));
        end

        // ---- reset while way 1 is in LOCK and owns the bus ----
        rst_n = 1'b0;
        step();
        check_reset4("midrst");
        rst_n = 1'b1;
        sv4 = '0; br4 = '0;
        step();
        check("post.sr", 8'(sr4), 8'hf);
        check("post.ev", 8'(ev4), 8'h0);
        check("post.gr", 8'(gr4), 8'h0);
        check("post.kw", 8'(kw4), 8'hf);

        // Pointers were reset too: with both 0 and 2 requesting, way 0 wins again.
        br4 = 4'b0101;
        step();
        check("post.regrant", 8'(gr4), 8'h1);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
